// File: rtl/ex_resolve.sv
// Execute-stage resolution: writeback FIFO, branch/jump redirect, epoch squash.
// Optional overflow trap is enabled by defining EX_RESOLVE_OVERFLOW_TRAP_EN.
module ex_resolve #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_epoch,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic            in_is_branch,
  input  logic            in_is_jal,
  input  logic            in_is_jalr,
  input  logic            in_is_arith,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_overflow,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_we,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_valid,
  input  logic            trap_ack,
  output logic [XLEN-1:0] trap_pc,
  output logic            epoch
);

  typedef enum logic {RUN, TRAP} state_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            we;
  } wb_ent_t;

  state_t          state, state_nxt;
  wb_ent_t         fifo [2];
  wb_ent_t         ent;
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count;
  logic            live, taken, ovf_trap, push, pop;
  logic [XLEN-1:0] tgt;

  // in_ready depends only on registered state, never on wb_ready
  assign in_ready = (state == RUN) && (count < 2'd2);
  assign live     = in_valid && in_ready && (in_epoch == epoch);
  assign taken    = in_is_jal || in_is_jalr || (in_is_branch && alu_zero);

`ifdef EX_RESOLVE_OVERFLOW_TRAP_EN
  assign ovf_trap   = live && in_is_arith && alu_overflow;
  assign trap_valid = (state == TRAP);
`else
  logic unused_ovf;
  assign unused_ovf = alu_overflow;
  assign ovf_trap   = 1'b0;
  assign trap_valid = 1'b0;
`endif

  assign push = live && !in_is_branch && !ovf_trap;
  assign pop  = wb_valid && wb_ready;
  assign tgt  = in_is_jalr ? (alu_result & ~XLEN'(1)) : (in_pc + in_imm);

  always_comb begin
    ent.rd   = in_rd;
    ent.data = (in_is_jal || in_is_jalr) ? (in_pc + XLEN'(4)) : alu_result;
    ent.we   = in_reg_write && (in_rd != 5'd0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (ovf_trap) state_nxt = TRAP;
      TRAP:    if (trap_ack) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) fifo[k] <= '0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      count          <= 2'd0;
      epoch          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      trap_pc        <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= ent;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      // A trapping instruction never redirects; either event opens a new epoch
      redirect_valid <= live && taken && !ovf_trap;
      if (live && taken && !ovf_trap) redirect_pc <= tgt;
      if ((live && taken) || ovf_trap) epoch <= ~epoch;
      if (ovf_trap) trap_pc <= in_pc;
    end
  end

  assign wb_valid = (count != 2'd0);
  assign wb_rd    = fifo[rd_ptr].rd;
  assign wb_data  = fifo[rd_ptr].data;
  assign wb_we    = fifo[rd_ptr].we;

endmodule

// File: tb/tb_ex_resolve.sv
// Scoreboard bench for ex_resolve: directed cases, random traffic, mid-run reset.
module tb_ex_resolve;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0, in_ready, in_epoch = 1'b0;
  logic [XLEN-1:0] in_pc = '0, in_imm = '0, alu_result = '0;
  logic [4:0]      in_rd = '0;
  logic            in_reg_write = 1'b0, in_is_branch = 1'b0, in_is_jal = 1'b0;
  logic            in_is_jalr = 1'b0, in_is_arith = 1'b0, alu_zero = 1'b0, alu_overflow = 1'b0;
  logic            wb_valid, wb_ready = 1'b0, wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data, redirect_pc, trap_pc;
  logic            redirect_valid, trap_valid, trap_ack = 1'b0, epoch;

  always #5 clk = ~clk;

  ex_resolve #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_epoch(in_epoch), .in_pc(in_pc), .in_imm(in_imm), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_is_branch(in_is_branch), .in_is_jal(in_is_jal),
    .in_is_jalr(in_is_jalr), .in_is_arith(in_is_arith), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_ack(trap_ack), .trap_pc(trap_pc), .epoch(epoch)
  );

  typedef struct {
    logic [31:0] pc, imm, res;
    logic [4:0]  rd;
    logic        rw, br, jal, jalr, arith, zero, ovf, ep;
  } ins_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } wb_t;

  wb_t         wb_q[$];
  logic [31:0] redir_q[$];
  logic        m_epoch = 1'b0, m_trap = 1'b0;
  logic [31:0] m_trap_pc = '0;
  int          tests = 0, fails = 0;
  bit          in_rst = 1'b1;
  int          wb_mode = 1;  // 0: hold wb_ready low, 1: high, 2: random
  ins_t        cur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one call per accepted instruction
  function automatic void model(input ins_t i);
    wb_t e;
    if (i.ep != m_epoch) return;
`ifdef EX_RESOLVE_OVERFLOW_TRAP_EN
    if (i.arith && i.ovf) begin
      m_trap    = 1'b1;
      m_trap_pc = i.pc;
      m_epoch   = ~m_epoch;
      return;
    end
`endif
    if (!i.br) begin
      e.rd   = i.rd;
      e.data = (i.jal || i.jalr) ? i.pc + 32'd4 : i.res;
      e.we   = i.rw && (i.rd != 5'd0);
      wb_q.push_back(e);
    end
    if (i.jal || i.jalr || (i.br && i.zero)) begin
      redir_q.push_back(i.jalr ? (i.res & 32'hFFFF_FFFE) : i.pc + i.imm);
      m_epoch = ~m_epoch;
    end
  endfunction

  function automatic ins_t mk(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] res, input logic [4:0] rd,
                              input logic zero, input logic ovf, input logic ep);
    ins_t i;
    i.pc = pc; i.imm = imm; i.res = res; i.rd = rd; i.zero = zero; i.ovf = ovf; i.ep = ep;
    i.rw = 1'b1; i.br = 1'b0; i.jal = 1'b0; i.jalr = 1'b0; i.arith = 1'b0;
    case (kind)
      0: i.arith = 1'b1;
      2: begin i.br = 1'b1; i.rw = 1'b0; end
      3: i.jal = 1'b1;
      4: i.jalr = 1'b1;
      5: i.rw = 1'b0;
      default: ;
    endcase
    return i;
  endfunction

  function automatic ins_t rnd();
    logic [4:0] rd = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
    logic ep = ($urandom % 5 == 0) ? ~m_epoch : m_epoch;
    return mk(int'($urandom % 6), $urandom & 32'hFFFF_FFFC, $urandom, $urandom, rd,
              1'($urandom), ($urandom % 4 == 0), ep);
  endfunction

  task automatic cyc_begin();
    @(negedge clk);
    wb_ready = (wb_mode == 2) ? ($urandom % 4 != 0) : (wb_mode == 1);
    trap_ack = m_trap && ($urandom % 3 == 0);
  endtask

  task automatic send(input ins_t i);
    int  n = 0;
    bit  acc = 0;
    cur = i;
    while (!acc && n < 100) begin
      cyc_begin();
      in_valid = 1'b1; in_epoch = cur.ep; in_pc = cur.pc; in_imm = cur.imm;
      in_rd = cur.rd; in_reg_write = cur.rw; in_is_branch = cur.br; in_is_jal = cur.jal;
      in_is_jalr = cur.jalr; in_is_arith = cur.arith; alu_result = cur.res;
      alu_zero = cur.zero; alu_overflow = cur.ovf;
      #2;
      if (in_ready) begin acc = 1; model(cur); end
      if (trap_ack && m_trap) m_trap = 1'b0;
      n++;
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cyc_begin();
      in_valid = 1'b0;
      #2;
      if (trap_ack && m_trap) m_trap = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    wb_mode = 1;
    while ((wb_q.size() != 0 || m_trap || redir_q.size() != 0) && n < 200) begin
      idle(1); n++;
    end
    idle(1);
    chk("drain_empty", wb_q.size(), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_trap_valid", trap_valid, 0);
    chk("rst_trap_pc", trap_pc, 0);
    chk("rst_epoch", epoch, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  // Monitor: compares DUT outputs against the scoreboard every cycle
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!in_rst) begin
        chk("epoch", epoch, m_epoch);
        chk("wb_valid", wb_valid, wb_q.size() != 0);
        chk("in_ready", in_ready, !m_trap && wb_q.size() < 2);
        chk("trap_valid", trap_valid, m_trap);
        if (m_trap) chk("trap_pc", trap_pc, m_trap_pc);
        if (redir_q.size() != 0) begin
          chk("redirect_valid", redirect_valid, 1);
          chk("redirect_pc", redirect_pc, redir_q.pop_front());
        end else begin
          chk("redirect_idle", redirect_valid, 0);
        end
        if (wb_valid && wb_ready && wb_q.size() != 0) begin
          e = wb_q.pop_front();
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_data", wb_data, e.data);
          chk("wb_we", wb_we, e.we);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    in_rst = 1'b0;

    // Writeback, rd=0, branches, squash, JALR
    wb_mode = 1;
    send(mk(0, 32'h10, 32'h0, 32'h7, 5'd5, 1'b0, 1'b0, m_epoch));
    send(mk(1, 32'h14, 32'h0, 32'h55, 5'd0, 1'b0, 1'b0, m_epoch));
    idle(2);
    send(mk(2, 32'h100, 32'h20, 32'h0, 5'd0, 1'b1, 1'b0, m_epoch));
    idle(1);
    send(mk(2, 32'h120, 32'h20, 32'h0, 5'd0, 1'b0, 1'b0, m_epoch));
    send(mk(1, 32'h104, 32'h0, 32'h99, 5'd3, 1'b0, 1'b0, ~m_epoch));
    send(mk(4, 32'h200, 32'h0, 32'h1003, 5'd1, 1'b0, 1'b0, m_epoch));
    idle(2);

    // Backpressure: fill both entries, hold, then drain in order
    wb_mode = 0;
    send(mk(1, 32'h40, 32'h0, 32'hAAAA, 5'd6, 1'b0, 1'b0, m_epoch));
    send(mk(1, 32'h44, 32'h0, 32'hBBBB, 5'd7, 1'b0, 1'b0, m_epoch));
    idle(3);
    wb_mode = 1;
    idle(3);

    // Overflowing ADD: traps when enabled, else writes back
    send(mk(0, 32'h300, 32'h0, 32'h8000_0000, 5'd9, 1'b0, 1'b1, m_epoch));
    idle(2);
    drain();

    wb_mode = 2;
    for (int k = 0; k < 300; k++) begin
      send(rnd());
      if ($urandom % 4 == 0) idle(1);
    end
    drain();

    // Reset while full with a redirect target registered
    wb_mode = 0;
    send(mk(3, 32'h400, 32'h40, 32'h0, 5'd1, 1'b0, 1'b0, m_epoch));
    send(mk(1, 32'h440, 32'h0, 32'h1234, 5'd2, 1'b0, 1'b0, m_epoch));
    idle(2);
    @(negedge clk);
    reset = 1'b1;
    in_rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk_reset_vals();
    wb_q.delete();
    redir_q.delete();
    m_epoch = 1'b0;
    m_trap = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    in_rst = 1'b0;

    wb_mode = 2;
    for (int k = 0; k < 40; k++) send(rnd());
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_resolve.md
# ex_resolve

Execute-stage resolution block that sits directly after the combinational ALU and consumes its `result`, `zero_flag` and `overflow` outputs. It turns them into a buffered register-writeback stream, a one-cycle fetch redirect for taken branches and jumps, and an optional overflow trap. Wrong-path instructions are squashed with a one-bit epoch. Output buffering is a 2-entry FIFO with valid/ready handshakes on both sides.

## Interface
Parameters:
- `XLEN`, 32, datapath width; must match ALU width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: ALU-stage instruction valid.
- `in_ready` out 1: block accepts the instruction this cycle.
- `in_epoch` in 1: fetch epoch tag of the instruction.
- `in_pc` in XLEN: instruction PC.
- `in_imm` in XLEN: sign-extended immediate.
- `in_rd` in 5: destination register.
- `in_reg_write` in 1: instruction writes rd.
- `in_is_branch` in 1: conditional branch.
- `in_is_jal` in 1: JAL.
- `in_is_jalr` in 1: JALR.
- `in_is_arith` in 1: signed ADD/SUB instruction eligible for overflow trap.
- `alu_result` in XLEN: ALU result.
- `alu_zero` in 1: ALU zero flag; for branches, 1 means condition true.
- `alu_overflow` in 1: ALU signed overflow.
- `wb_valid` out 1, `wb_ready` in 1: writeback handshake.
- `wb_rd` out 5, `wb_data` out XLEN, `wb_we` out 1: writeback payload.
- `redirect_valid` out 1: one-cycle pulse.
- `redirect_pc` out XLEN: new fetch PC.
- `trap_valid` out 1, `trap_ack` in 1: trap handshake.
- `trap_pc` out XLEN: PC of the trapping instruction.
- `epoch` out 1: current epoch, for fetch tagging.

## Operation
- **Accept:** `acc = in_valid & in_ready`. `in_ready = (state==RUN) & (count<2)`. `in_ready` has no combinational path from `wb_ready`.
- **Squash:** an accepted instruction with `in_epoch != epoch` is consumed and discarded. It causes no FIFO push, no redirect and no trap.
- **Taken condition:** `taken = in_is_jal | in_is_jalr | (in_is_branch & alu_zero)`.
- **Redirect target:**
  - `(alu_result & ~1)` for JALR.
  - Otherwise `in_pc + in_imm`, computed mod 2^XLEN.
- **Writeback data:** `wb_data = in_pc + 4` for JAL/JALR, else `alu_result`. `wb_we = in_reg_write & (in_rd != 0)`.
- **Pushes:** branches push nothing. All other live accepted instructions push one FIFO entry.
- **Taken, live instruction:** registers `redirect_valid=1` and `redirect_pc` for the next cycle, and toggles `epoch`.
- **FIFO:** 2 entries, count 0..2, wrap-around read/write pointers. When a push and a pop occur in the same cycle, count is unchanged. `wb_valid = (count!=0)`; head data is held stable while `wb_valid & ~wb_ready`.
- **FSM states:** RUN, TRAP.
  - RUN→TRAP: a live accepted instruction with `in_is_arith & alu_overflow`, only when OVERFLOW_TRAP_EN is defined. The instruction is not pushed, `trap_pc <= in_pc`, and `epoch` toggles.
  - TRAP: `trap_valid=1`, `in_ready=0`. The FIFO keeps draining.
  - TRAP→RUN: on `trap_ack`.
- **Reset:**
  - State RUN, count 0, pointers 0, `epoch=0`.
  - `wb_valid=0`, `redirect_valid=0`, `redirect_pc=0`, `trap_valid=0`, `trap_pc=0`, `wb_*` payload 0.
  - Reset mid-transfer discards FIFO contents and any pending trap.

## Timing
- Accepted instruction reaches `wb_valid` at earliest the next cycle (1-cycle latency).
- Redirect asserts the cycle after acceptance, for exactly 1 cycle. The new `epoch` is visible in that same cycle.
- Trap: `trap_valid` rises the cycle after acceptance and holds until the cycle `trap_ack` is sampled high. `in_ready` returns high the cycle after that.
- Full FIFO (count=2): `in_ready=0` even if `wb_ready=1`. At count=1, a simultaneous push and pop is allowed.
- Squashed instructions take one accept cycle each.

## Configuration
- `EX_RESOLVE_OVERFLOW_TRAP_EN`:
  - Defined: the overflow trap FSM path is active.
  - Undefined: `alu_overflow` is ignored, overflowing results are written back normally, `trap_valid` is tied 0, and TRAP is unreachable.

## Test plan
- **ADD writeback:** ADD, rd=5, alu_result=0x0000_0007 → next cycle `wb_valid=1`, `wb_rd=5`, `wb_data=7`, `wb_we=1`. rd=0 → `wb_we=0`.
- **Branches:**
  - BNE at pc=0x100, imm=0x20, alu_zero=1 → `redirect_valid` one cycle, `redirect_pc=0x120`, `epoch` 0→1, no wb entry.
  - Same with alu_zero=0 → no redirect.
  - Next instruction with in_epoch=0 → discarded.
- **JALR:** pc=0x200, alu_result=0x1003 → `redirect_pc=0x1002`, `wb_data=0x204`.
- **Backpressure:** hold `wb_ready=0` and push 2 instructions → `in_ready=0`, head stable. Release `wb_ready` → in-order drain, count 2→1→0.
- **Overflow (macro defined):** ADD, alu_overflow=1, pc=0x300 → `trap_valid=1`, `trap_pc=0x300`, `in_ready=0` until `trap_ack`, no wb entry. With the macro undefined, the same stimulus writes back normally.
- **Reset:** assert `reset` with count=2 and TRAP active → all outputs at reset values the next cycle.
